// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: 4-way round-robin/fixed-priority grant arbiter with 4:1 mux select and beat hold limit
// Ports: clk, rst_n (async, active-low); req/last per-requester level inputs; out_ready downstream accept;
//        sel/gnt registered grant index and one-hot; out_valid/out_last combinational beat qualifiers;
//        busy high while granted; timeout one-cycle pulse after a hold-limit release.
module rr_mux4_arbiter #(
  parameter int RR_MODE  = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] last,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy,
  output logic       timeout
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0] state;
  logic [1:0] ptr, base, win;
  logic [7:0] cnt;
  logic       xfer, rel_to, rel;
  assign base = (RR_MODE != 0) ? ptr : 2'd0;
  // Scan from the farthest candidate back toward base so the nearest set bit wins.
  always_comb begin
    win = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (req[base + 2'(k)]) win = base + 2'(k);
  end
  assign busy      = state == GRANT;
  assign out_valid = busy & req[sel];
  assign out_last  = out_valid & last[sel];
  assign xfer      = out_valid & out_ready;
  // A last beat that coincides with the limit is an ordinary release, hence !last.
  assign rel_to    = (HOLD_MAX != 0) && xfer && !last[sel] && cnt == 8'(HOLD_MAX - 1);
  assign rel       = !req[sel] || (xfer && last[sel]) || rel_to;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= 2'd0;
      gnt     <= 4'd0;
      ptr     <= 2'd0;
      cnt     <= 8'd0;
      timeout <= 1'b0;
    end else begin
      timeout <= rel_to;
      if (!busy) begin
        if (|req) begin
          state <= GRANT;
          sel   <= win;
          gnt   <= 4'b1 << win;
          cnt   <= 8'd0;
        end
      end else if (rel) begin
        state <= IDLE;
        gnt   <= 4'd0;
        cnt   <= 8'd0;
        ptr   <= sel + 2'd1;
      end else if (xfer && cnt != 8'hff) begin
        cnt <= cnt + 8'd1;
      end
    end
endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// tb_rr_mux4_arbiter: directed checks of round-robin, fixed priority, hold limit, stall, reset and abandon
module tb_rr_mux4_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'd0, last = 4'd0;
  logic       out_ready = 1'b0;
  logic [1:0] r_sel, f_sel, h_sel;
  logic [3:0] r_gnt, f_gnt, h_gnt;
  logic       r_ov, f_ov, h_ov, r_ol, f_ol, h_ol, r_busy, f_busy, h_busy, r_to, f_to, h_to;
  int         total = 0, passed = 0;
  always #5 clk = ~clk;
  rr_mux4_arbiter #(.RR_MODE(1), .HOLD_MAX(8)) u_rr (.clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .out_ready(out_ready), .sel(r_sel), .gnt(r_gnt), .out_valid(r_ov), .out_last(r_ol), .busy(r_busy), .timeout(r_to));
  rr_mux4_arbiter #(.RR_MODE(0), .HOLD_MAX(8)) u_fx (.clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .out_ready(out_ready), .sel(f_sel), .gnt(f_gnt), .out_valid(f_ov), .out_last(f_ol), .busy(f_busy), .timeout(f_to));
  rr_mux4_arbiter #(.RR_MODE(1), .HOLD_MAX(4)) u_h4 (.clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .out_ready(out_ready), .sel(h_sel), .gnt(h_gnt), .out_valid(h_ov), .out_last(h_ol), .busy(h_busy), .timeout(h_to));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'd0;
    last = 4'd0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    last = 4'b1111;
    out_ready = 1'b1;
    tick();
    tick();
    total++; if ({r_gnt, r_sel, r_busy, r_ov, r_ol, r_to} !== 10'd0) $display("FAIL reset_rr got %b exp 0", {r_gnt, r_sel, r_busy, r_ov, r_ol, r_to}); else passed++;
    total++; if ({f_gnt, f_sel, f_busy, f_ov, f_ol, f_to} !== 10'd0) $display("FAIL reset_fx got %b exp 0", {f_gnt, f_sel, f_busy, f_ov, f_ol, f_to}); else passed++;
    total++; if ({h_gnt, h_sel, h_busy, h_ov, h_ol, h_to} !== 10'd0) $display("FAIL reset_h4 got %b exp 0", {h_gnt, h_sel, h_busy, h_ov, h_ol, h_to}); else passed++;
  endtask
  task automatic test_round_robin();
    do_reset();
    req = 4'b1111;
    last = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (r_gnt !== 4'(1 << (i % 4))) $display("FAIL rr_gnt[%0d] got %b exp %b", i, r_gnt, 4'(1 << (i % 4))); else passed++;
      total++; if (r_sel !== 2'(i % 4) || r_ol !== 1'b1) $display("FAIL rr_sel[%0d] got %0d/%b exp %0d/1", i, r_sel, r_ol, i % 4); else passed++;
      tick();
      total++; if (r_gnt !== 4'd0 || r_busy !== 1'b0) $display("FAIL rr_bubble[%0d] got %b/%b exp 0000/0", i, r_gnt, r_busy); else passed++;
    end
  endtask
  task automatic test_fixed_priority();
    do_reset();
    req = 4'b1010;
    last = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (f_gnt !== ((i % 2 == 0) ? 4'b0010 : 4'b0000)) $display("FAIL fx_gnt[%0d] got %b exp %b", i, f_gnt, (i % 2 == 0) ? 4'b0010 : 4'b0000); else passed++;
    end
  endtask
  task automatic test_hold_limit();
    do_reset();
    req = 4'b0100;
    last = 4'b0000;
    out_ready = 1'b1;
    tick();
    total++; if (h_gnt !== 4'b0100 || h_sel !== 2'd2) $display("FAIL hold_grant got %b/%0d exp 0100/2", h_gnt, h_sel); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (h_gnt !== 4'b0100 || h_to !== 1'b0) $display("FAIL hold_beat[%0d] got %b/%b exp 0100/0", i, h_gnt, h_to); else passed++;
    end
    tick();
    total++; if (h_gnt !== 4'b0000 || h_to !== 1'b1) $display("FAIL hold_release got %b/%b exp 0000/1", h_gnt, h_to); else passed++;
    total++; if (r_gnt !== 4'b0100 || r_to !== 1'b0) $display("FAIL hold8_still got %b/%b exp 0100/0", r_gnt, r_to); else passed++;
    tick();
    total++; if (h_gnt !== 4'b0100 || h_to !== 1'b0) $display("FAIL hold_regrant got %b/%b exp 0100/0", h_gnt, h_to); else passed++;
    tick();
    tick();
    tick();
    last = 4'b0100;
    tick();
    total++; if (h_gnt !== 4'b0000 || h_to !== 1'b0) $display("FAIL hold_last_same got %b/%b exp 0000/0", h_gnt, h_to); else passed++;
  endtask
  task automatic test_stall();
    do_reset();
    req = 4'b0010;
    last = 4'b0010;
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (r_gnt !== 4'b0010 || r_ol !== 1'b1) $display("FAIL stall_hold[%0d] got %b/%b exp 0010/1", i, r_gnt, r_ol); else passed++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    total++; if (r_gnt !== 4'b0000) $display("FAIL stall_release got %b exp 0000", r_gnt); else passed++;
    last = 4'b0000;
    out_ready = 1'b0;
    tick();
    total++; if (h_gnt !== 4'b0010) $display("FAIL stall_regrant got %b exp 0010", h_gnt); else passed++;
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    total++; if (h_gnt !== 4'b0010 || h_to !== 1'b0) $display("FAIL stall_count got %b/%b exp 0010/0", h_gnt, h_to); else passed++;
    tick();
    total++; if (h_gnt !== 4'b0000 || h_to !== 1'b1) $display("FAIL stall_timeout got %b/%b exp 0000/1", h_gnt, h_to); else passed++;
  endtask
  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b0010;
    last = 4'b0010;
    out_ready = 1'b1;
    tick();
    tick();
    req = 4'b1000;
    last = 4'b0000;
    tick();
    total++; if (r_gnt !== 4'b1000 || r_sel !== 2'd3) $display("FAIL mid_grant got %b/%0d exp 1000/3", r_gnt, r_sel); else passed++;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (r_gnt !== 4'd0 || r_sel !== 2'd0 || r_busy !== 1'b0) $display("FAIL mid_async got %b/%0d/%b exp 0000/0/0", r_gnt, r_sel, r_busy); else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = 4'b1001;
    tick();
    total++; if (r_gnt !== 4'b0001 || r_sel !== 2'd0) $display("FAIL mid_regrant got %b/%0d exp 0001/0", r_gnt, r_sel); else passed++;
  endtask
  task automatic test_abandon();
    do_reset();
    req = 4'b0001;
    last = 4'b0000;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    req = 4'b0000;
    #1;
    total++; if (r_ov !== 1'b0 || r_busy !== 1'b1) $display("FAIL abandon_valid got %b/%b exp 0/1", r_ov, r_busy); else passed++;
    tick();
    total++; if (r_gnt !== 4'd0 || h_to !== 1'b0) $display("FAIL abandon_release got %b/%b exp 0000/0", r_gnt, h_to); else passed++;
    req = 4'b0011;
    tick();
    total++; if (r_gnt !== 4'b0010) $display("FAIL abandon_ptr got %b exp 0010", r_gnt); else passed++;
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    total++; if (r_gnt !== 4'd0 || r_busy !== 1'b0 || r_to !== 1'b0) $display("FAIL drop_on_load got %b/%b/%b exp 0000/0/0", r_gnt, r_busy, r_to); else passed++;
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_hold_limit();
    test_stall();
    test_reset_mid_burst();
    test_abandon();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
